// File: rtl/run_length_detector_if.sv
`default_nettype none
// ============================================================================
//  Module   : run_length_detector_if
//  Purpose  : Bundles the serial-input sample stream (en, x) and the
//             run-length report (y, y_valid, sat, evt_cnt) of the
//             run_length_detector.
//  Ports    : master - stream source / report consumer (drives en, x)
//             slave  - the detector (drives y, y_valid, sat, evt_cnt)
//  Revision : 1.0 - initial release
// ============================================================================
interface run_length_detector_if #(
   parameter int CNT_W = 2,
   parameter int EVT_W = 8
);
   logic             en;
   logic             x;
   logic [CNT_W-1:0] y;
   logic             y_valid;
   logic             sat;
   logic [EVT_W-1:0] evt_cnt;

   modport master (
      output en, x,
      input  y, y_valid, sat, evt_cnt
   );

   modport slave (
      input  en, x,
      output y, y_valid, sat, evt_cnt
   );
endinterface
`default_nettype wire

// File: rtl/run_length_detector.sv
`default_nettype none
// ============================================================================
//  Module   : run_length_detector
//  Purpose  : Serial run-length detector. Watches x for a 0 preamble followed
//             by a run of 1s and, on the terminating 0, reports the run
//             length (saturated at MAX_RUN, filtered below MIN_RUN).
//  Ports    : clk  - clock, all state updates on posedge
//             rst  - synchronous active-high reset
//             bus  - slave modport: en/x in, y/y_valid/sat/evt_cnt out
//  Revision : 1.0 - initial release
// ============================================================================
module run_length_detector #(
   parameter int CNT_W     = 2,
   parameter int MAX_RUN   = 3,
   parameter int MIN_RUN   = 1,
   parameter int DROP_OVER = 0,
   parameter int EVT_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   run_length_detector_if.slave  bus
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter legality checks
   // ------------------------------------------------------------------
   if ((MAX_RUN < 1) || (MAX_RUN > (2**CNT_W) - 1)) begin : g_bad_max_run
      $error("run_length_detector: MAX_RUN must be in 1..2^CNT_W-1");
   end
   if ((MIN_RUN < 1) || (MIN_RUN > MAX_RUN)) begin : g_bad_min_run
      $error("run_length_detector: MIN_RUN must be in 1..MAX_RUN");
   end

   localparam logic [CNT_W-1:0] C_MAX_RUN = CNT_W'(MAX_RUN);
   localparam logic [CNT_W-1:0] C_MIN_RUN = CNT_W'(MIN_RUN);
   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
   localparam logic [EVT_W-1:0] C_EVT_ONE = EVT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,   // no preamble seen yet
      S_ARMED = 2'd1,   // 0 seen, waiting for the first 1
      S_RUN   = 2'd2    // counting 1s
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] run_q,   run_d;
   logic             ovf_q,   ovf_d;
   logic [CNT_W-1:0] y_q,     y_d;
   logic             valid_q, valid_d;
   logic             sat_q,   sat_d;
   logic [EVT_W-1:0] evt_q,   evt_d;

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      ovf_d   = ovf_q;
      y_d     = y_q;
      valid_d = 1'b0;
      sat_d   = sat_q;
      evt_d   = evt_q;

      case (state_q)
         S_IDLE: begin
            if (bus.en && !bus.x) begin
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (bus.en && bus.x) begin
               state_d = S_RUN;
               run_d   = C_ONE;
               ovf_d   = 1'b0;
            end
         end
         S_RUN: begin
            if (bus.en) begin
               if (bus.x) begin
                  // Run counter saturates; ovf remembers that a 1 arrived
                  // while already at MAX_RUN.
                  if (run_q < C_MAX_RUN) begin
                     run_d = run_q + C_ONE;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else begin
                  // Terminating 0 is also the preamble of the next run.
                  state_d = S_ARMED;
                  if (ovf_q) begin
                     if (DROP_OVER == 0) begin
                        y_d     = C_MAX_RUN;
                        sat_d   = 1'b1;
                        valid_d = 1'b1;
                        evt_d   = evt_q + C_EVT_ONE;
                     end
                  end else if (run_q >= C_MIN_RUN) begin
                     y_d     = run_q;
                     sat_d   = 1'b0;
                     valid_d = 1'b1;
                     evt_d   = evt_q + C_EVT_ONE;
                  end
               end
            end
         end
         default: begin
            // Unused encoding: recover regardless of en.
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         run_q   <= '0;
         ovf_q   <= 1'b0;
         y_q     <= '0;
         valid_q <= 1'b0;
         sat_q   <= 1'b0;
         evt_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         ovf_q   <= ovf_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         sat_q   <= sat_d;
         evt_q   <= evt_d;
      end
   end

   assign bus.y       = y_q;
   assign bus.y_valid = valid_q;
   assign bus.sat     = sat_q;
   assign bus.evt_cnt = evt_q;

endmodule
`default_nettype wire

// File: tb/tb_run_length_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_length_detector
//  Purpose  : Self-checking bench for run_length_detector. Three instances
//             with different parameter sets share one stimulus stream and
//             are compared every cycle against a behavioural model that
//             tracks "preamble seen" and an unbounded count of 1s.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_run_length_detector;

   localparam int N = 3;
   // Instance configurations: A defaults, B drop+filter+narrow counter,
   // C wider run counter.
   localparam int A_CNT = 2, A_MAX = 3, A_MIN = 1, A_DROP = 0, A_EVT = 8;
   localparam int B_CNT = 2, B_MAX = 3, B_MIN = 2, B_DROP = 1, B_EVT = 2;
   localparam int C_CNT = 3, C_MAX = 5, C_MIN = 1, C_DROP = 0, C_EVT = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   run_length_detector_if #(.CNT_W(A_CNT), .EVT_W(A_EVT)) if_a ();
   run_length_detector_if #(.CNT_W(B_CNT), .EVT_W(B_EVT)) if_b ();
   run_length_detector_if #(.CNT_W(C_CNT), .EVT_W(C_EVT)) if_c ();

   run_length_detector #(.CNT_W(A_CNT), .MAX_RUN(A_MAX), .MIN_RUN(A_MIN),
                         .DROP_OVER(A_DROP), .EVT_W(A_EVT))
      u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   run_length_detector #(.CNT_W(B_CNT), .MAX_RUN(B_MAX), .MIN_RUN(B_MIN),
                         .DROP_OVER(B_DROP), .EVT_W(B_EVT))
      u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
   run_length_detector #(.CNT_W(C_CNT), .MAX_RUN(C_MAX), .MIN_RUN(C_MIN),
                         .DROP_OVER(C_DROP), .EVT_W(C_EVT))
      u_dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

   int cfg_max  [N] = '{A_MAX,  B_MAX,  C_MAX};
   int cfg_min  [N] = '{A_MIN,  B_MIN,  C_MIN};
   int cfg_drop [N] = '{A_DROP, B_DROP, C_DROP};
   int cfg_evt  [N] = '{A_EVT,  B_EVT,  C_EVT};

   // Reference model state
   bit m_pre [N];   // a 0 has been seen (preamble present)
   int m_len [N];   // number of 1s since that 0, unbounded
   int m_y   [N];
   int m_sat [N];
   int m_v   [N];
   int m_cnt [N];

   int n_pass = 0;
   int n_chk  = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_step(input int k, input bit r, input bit e, input bit xb);
      m_v[k] = 0;
      if (r) begin
         m_pre[k] = 0; m_len[k] = 0;
         m_y[k] = 0; m_sat[k] = 0; m_cnt[k] = 0;
      end else if (e) begin
         if (xb) begin
            if (m_pre[k]) m_len[k]++;
         end else begin
            if (m_pre[k] && m_len[k] > 0) begin
               if (m_len[k] > cfg_max[k]) begin
                  if (cfg_drop[k] == 0) begin
                     m_y[k] = cfg_max[k]; m_sat[k] = 1; m_v[k] = 1;
                     m_cnt[k] = (m_cnt[k] + 1) % (2 ** cfg_evt[k]);
                  end
               end else if (m_len[k] >= cfg_min[k]) begin
                  m_y[k] = m_len[k]; m_sat[k] = 0; m_v[k] = 1;
                  m_cnt[k] = (m_cnt[k] + 1) % (2 ** cfg_evt[k]);
               end
            end
            m_pre[k] = 1;
            m_len[k] = 0;
         end
      end
   endtask

   task automatic compare_all();
      check("a_y",   int'(if_a.y),       m_y[0]);
      check("a_v",   int'(if_a.y_valid), m_v[0]);
      check("a_sat", int'(if_a.sat),     m_sat[0]);
      check("a_cnt", int'(if_a.evt_cnt), m_cnt[0]);
      check("b_y",   int'(if_b.y),       m_y[1]);
      check("b_v",   int'(if_b.y_valid), m_v[1]);
      check("b_sat", int'(if_b.sat),     m_sat[1]);
      check("b_cnt", int'(if_b.evt_cnt), m_cnt[1]);
      check("c_y",   int'(if_c.y),       m_y[2]);
      check("c_v",   int'(if_c.y_valid), m_v[2]);
      check("c_sat", int'(if_c.sat),     m_sat[2]);
      check("c_cnt", int'(if_c.evt_cnt), m_cnt[2]);
   endtask

   // Drive one cycle of stimulus, advance the model on the edge and
   // compare all instances 1 time unit after it.
   task automatic step(input bit r, input bit e, input bit xb);
      rst = r;
      if_a.en = e; if_a.x = xb;
      if_b.en = e; if_b.x = xb;
      if_c.en = e; if_c.x = xb;
      @(posedge clk);
      for (int k = 0; k < N; k++) model_step(k, r, e, xb);
      #1;
      compare_all();
   endtask

   task automatic feed(input string bits);
      for (int i = 0; i < bits.len(); i++) step(1'b0, 1'b1, bits[i] == "1");
   endtask

   initial begin
      rst = 1'b1;
      if_a.en = 1'b0; if_a.x = 1'b0;
      if_b.en = 1'b0; if_b.x = 1'b0;
      if_c.en = 1'b0; if_c.x = 1'b0;

      // Reset state
      step(1'b1, 1'b0, 1'b0);
      check("rst_y",   int'(if_a.y), 0);
      check("rst_cnt", int'(if_a.evt_cnt), 0);

      // Basic run of two
      feed("0110");
      check("t1_v",   int'(if_a.y_valid), 1);
      check("t1_y",   int'(if_a.y), 2);
      check("t1_sat", int'(if_a.sat), 0);
      check("t1_cnt", int'(if_a.evt_cnt), 1);
      feed("0");
      check("t1_v0",   int'(if_a.y_valid), 0);
      check("t1_hold", int'(if_a.y), 2);

      // No preamble, then a run of one
      step(1'b1, 1'b0, 1'b0);
      feed("1110");
      check("t2_nocnt", int'(if_a.evt_cnt), 0);
      feed("10");
      check("t2_y",   int'(if_a.y), 1);
      check("t2_cnt", int'(if_a.evt_cnt), 1);

      // Overflow: A saturates, B drops, C (MAX 5) reports 5 exactly
      step(1'b1, 1'b0, 1'b0);
      feed("0111110");
      check("t3_a_y",   int'(if_a.y), 3);
      check("t3_a_sat", int'(if_a.sat), 1);
      check("t3_b_v",   int'(if_b.y_valid), 0);
      check("t3_b_cnt", int'(if_b.evt_cnt), 0);
      check("t3_c_y",   int'(if_c.y), 5);
      check("t3_c_sat", int'(if_c.sat), 0);

      // Exactly MAX_RUN
      step(1'b1, 1'b0, 1'b0);
      feed("01110");
      check("t3x_y",   int'(if_a.y), 3);
      check("t3x_sat", int'(if_a.sat), 0);

      // Back-to-back runs and min-length filter
      step(1'b1, 1'b0, 1'b0);
      feed("010110");
      check("t4_a_cnt", int'(if_a.evt_cnt), 2);
      check("t4_b_cnt", int'(if_b.evt_cnt), 1);
      check("t4_b_y",   int'(if_b.y), 2);

      // Enable gating
      step(1'b1, 1'b0, 1'b0);
      feed("01");
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check("t5_gate_v", int'(if_a.y_valid), 0);
      end
      feed("10");
      check("t5_y",   int'(if_a.y), 2);
      check("t5_cnt", int'(if_a.evt_cnt), 1);

      // Reset mid-run discards it
      step(1'b1, 1'b0, 1'b0);
      feed("011");
      step(1'b1, 1'b1, 1'b0);
      feed("0");
      check("t6_v",   int'(if_a.y_valid), 0);
      check("t6_cnt", int'(if_a.evt_cnt), 0);

      // Counter wrap on B (EVT_W=2): 1,2,3,0,1
      step(1'b1, 1'b0, 1'b0);
      feed("0");
      for (int i = 1; i <= 5; i++) begin
         feed("110");
         check("t6_wrap", int'(if_b.evt_cnt), i % 4);
      end

      // Randomized traffic against the model
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 99) < 65);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
